// File: rtl/axi_wr_sched.sv
// Two-client write scheduler: splits long client transfers into bounded bursts for the AXI write
// master and interleaves the clients round-robin at burst boundaries.
module axi_wr_sched #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned ADDR_STEP  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  c0_valid,
  output logic                  c0_ready,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [15:0]           c0_beats,
  input  logic [DATA_WIDTH-1:0] c0_data,
  output logic                  c0_data_en,
  output logic                  c0_done,
  input  logic                  c1_valid,
  output logic                  c1_ready,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [15:0]           c1_beats,
  input  logic [DATA_WIDTH-1:0] c1_data,
  output logic                  c1_data_en,
  output logic                  c1_done,
  output logic                  m_wr_trig,
  output logic [7:0]            m_wr_len,
  output logic [ADDR_WIDTH-1:0] m_wr_addr,
  output logic [DATA_WIDTH-1:0] m_wr_data,
  input  logic                  m_wr_data_en,
  input  logic                  m_wr_ready,
  input  logic                  m_wr_done
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [15:0]           MaxLen   = 16'(BURST_LEN);

  state_e                state_q;
  logic [1:0]            act_q;
  logic [1:0]            done_q;
  logic                  grant_q;
  logic                  last_q;
  logic                  trig_q;
  logic [7:0]            len_q;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [ADDR_WIDTH-1:0] cur_q [2];
  logic [15:0]           rem_q [2];

  logic [1:0]            valid;
  logic [1:0]            ready;
  logic [ADDR_WIDTH-1:0] addr_in [2];
  logic [15:0]           beats_in [2];
  logic                  pick;

  assign valid       = {c1_valid, c0_valid};
  assign ready       = ~act_q & {2{init_end}};
  assign addr_in[0]  = c0_addr;
  assign addr_in[1]  = c1_addr;
  assign beats_in[0] = c0_beats;
  assign beats_in[1] = c1_beats;

  // With both channels pending, the one that did not own the last burst goes next.
  assign pick = (act_q == 2'b11) ? ~last_q : act_q[1];

  function automatic logic [7:0] burst_len(input logic [15:0] rem);
    return (rem < MaxLen) ? rem[7:0] : MaxLen[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      act_q   <= '0;
      done_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      trig_q  <= 1'b0;
      len_q   <= '0;
      maddr_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cur_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      done_q <= '0;
      trig_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (valid[i] && ready[i]) begin
          cur_q[i] <= addr_in[i];
          rem_q[i] <= beats_in[i];
          if (beats_in[i] == 16'd0) done_q[i] <= 1'b1;
          else                      act_q[i]  <= 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (init_end && m_wr_ready && (|act_q)) begin
            grant_q <= pick;
            trig_q  <= 1'b1;
            len_q   <= burst_len(rem_q[pick]);
            maddr_q <= cur_q[pick];
            state_q <= StIssue;
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (m_wr_done) begin
            rem_q[grant_q] <= rem_q[grant_q] - 16'(len_q);
            cur_q[grant_q] <= cur_q[grant_q] + ADDR_WIDTH'(len_q) * AddrStep;
            last_q         <= grant_q;
            state_q        <= StIdle;
            if (rem_q[grant_q] == 16'(len_q)) begin
              act_q[grant_q]  <= 1'b0;
              done_q[grant_q] <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign c0_ready   = ready[0];
  assign c1_ready   = ready[1];
  assign c0_done    = done_q[0];
  assign c1_done    = done_q[1];
  assign m_wr_trig  = trig_q;
  assign m_wr_len   = len_q;
  assign m_wr_addr  = maddr_q;
  // Data path is only meaningful once a burst has been granted.
  assign m_wr_data  = (state_q == StIdle) ? '0 : (grant_q ? c1_data : c0_data);
  assign c0_data_en = m_wr_data_en && (state_q == StWait) && !grant_q;
  assign c1_data_en = m_wr_data_en && (state_q == StWait) && grant_q;

endmodule

// File: tb/tb_axi_wr_sched.sv
// Directed bench for axi_wr_sched with a small write-master responder that logs every burst.
module tb_axi_wr_sched;

  localparam int AW = 26;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_end = 1'b1;
  logic          c0_valid = 1'b0, c1_valid = 1'b0;
  logic          c0_ready, c1_ready;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [15:0]   c0_beats = '0, c1_beats = '0;
  logic [DW-1:0] c0_data = '0, c1_data = '0;
  logic          c0_data_en, c1_data_en, c0_done, c1_done;
  logic          m_wr_trig;
  logic [7:0]    m_wr_len;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  logic          m_wr_data_en = 1'b0;
  logic          m_wr_ready, m_wr_done;

  axi_wr_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(8), .ADDR_STEP(2)) dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_addr(c0_addr), .c0_beats(c0_beats),
    .c0_data(c0_data), .c0_data_en(c0_data_en), .c0_done(c0_done),
    .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_addr(c1_addr), .c1_beats(c1_beats),
    .c1_data(c1_data), .c1_data_en(c1_data_en), .c1_done(c1_done),
    .m_wr_trig(m_wr_trig), .m_wr_len(m_wr_len), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_data_en(m_wr_data_en), .m_wr_ready(m_wr_ready), .m_wr_done(m_wr_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-master model: takes a burst on trig, completes it mdelay cycles later.
  logic [AW-1:0] log_addr [$];
  logic [7:0]    log_len  [$];
  int            mdelay = 4;
  int            done_cyc = 0;
  bit            busy = 1'b0;
  int            cnt = 0;

  initial begin
    m_wr_ready = 1'b1;
    m_wr_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0; m_wr_ready = 1'b1; m_wr_done = 1'b0;
      end else begin
        m_wr_done = 1'b0;
        if (m_wr_trig) begin
          log_addr.push_back(m_wr_addr);
          log_len.push_back(m_wr_len);
          busy = 1'b1; m_wr_ready = 1'b0; cnt = mdelay;
        end else if (busy) begin
          cnt--;
          if (cnt == 0) begin
            m_wr_done = 1'b1; busy = 1'b0; m_wr_ready = 1'b1; done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; c0_valid = 1'b0; c1_valid = 1'b0; m_wr_data_en = 1'b0; init_end = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic post(input int ch, input logic [AW-1:0] a, input logic [15:0] b);
    @(negedge clk);
    if (ch == 0) begin c0_valid = 1'b1; c0_addr = a; c0_beats = b; end
    else         begin c1_valid = 1'b1; c1_addr = a; c1_beats = b; end
    @(negedge clk);
    c0_valid = 1'b0; c1_valid = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int budget, output bit seen, output int at);
    seen = 1'b0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((ch == 0) ? c0_done : c1_done) begin seen = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic wait_trig(input int budget, output bit seen, output int at);
    seen = 1'b0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_wr_trig) begin seen = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic check_burst(input string tag, input int idx, input logic [AW-1:0] a,
                             input logic [7:0] l);
    if (idx < log_addr.size()) begin
      check({tag, "_addr"}, 64'(log_addr[idx]), 64'(a));
      check({tag, "_len"}, 64'(log_len[idx]), 64'(l));
    end else begin
      check({tag, "_present"}, 64'(0), 64'(1));
    end
  endtask

  initial begin
    bit seen, d0, d1;
    int at, base, raise, ndone, ntrig;
    logic [7:0] pat;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_trig", 64'(m_wr_trig), 64'(0));
    check("rst_len", 64'(m_wr_len), 64'(0));
    check("rst_addr", 64'(m_wr_addr), 64'(0));
    check("rst_data", 64'(m_wr_data), 64'(0));
    check("rst_done", 64'({c1_done, c0_done}), 64'(0));
    check("rst_ready", 64'({c1_ready, c0_ready}), 64'(3));
    init_end = 1'b0;
    #1 check("rst_ready_noinit", 64'({c1_ready, c0_ready}), 64'(0));
    init_end = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 1: single client, 20 beats -> 8,8,4
    base = log_addr.size();
    post(0, 26'h100, 16'd20);
    check("t1_ready_busy", 64'(c0_ready), 64'(0));
    wait_done(0, 300, seen, at);
    check("t1_done_seen", 64'(seen), 64'(1));
    check("t1_done_lat", 64'(at), 64'(done_cyc + 1));
    check("t1_nbursts", 64'(log_addr.size() - base), 64'(3));
    check_burst("t1_b0", base, 26'h100, 8'd8);
    check_burst("t1_b1", base + 1, 26'h110, 8'd8);
    check_burst("t1_b2", base + 2, 26'h120, 8'd4);
    check("t1_len_hold", 64'(m_wr_len), 64'(4));
    check("t1_addr_hold", 64'(m_wr_addr), 64'(26'h120));
    @(negedge clk);
    check("t1_done_pulse", 64'(c0_done), 64'(0));
    check("t1_ready_again", 64'(c0_ready), 64'(1));

    // 2: both clients together interleave
    do_reset();
    base = log_addr.size();
    @(negedge clk);
    c0_valid = 1'b1; c0_addr = 26'h0;    c0_beats = 16'd16;
    c1_valid = 1'b1; c1_addr = 26'h1000; c1_beats = 16'd16;
    @(negedge clk);
    c0_valid = 1'b0; c1_valid = 1'b0;
    d0 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (c0_done) d0 = 1'b1;
      if (c1_done) d1 = 1'b1;
      if (d0 && d1) break;
    end
    check("t2_both_done", 64'({d1, d0}), 64'(3));
    check("t2_nbursts", 64'(log_addr.size() - base), 64'(4));
    check_burst("t2_b0", base, 26'h0, 8'd8);
    check_burst("t2_b1", base + 1, 26'h1000, 8'd8);
    check_burst("t2_b2", base + 2, 26'h10, 8'd8);
    check_burst("t2_b3", base + 3, 26'h1010, 8'd8);

    // 3: zero-beat request completes without a burst
    base = log_addr.size();
    post(1, 26'h3000, 16'd0);
    check("t3_done", 64'(c1_done), 64'(1));
    @(negedge clk);
    check("t3_done_pulse", 64'(c1_done), 64'(0));
    repeat (10) @(negedge clk);
    check("t3_no_trig", 64'(log_addr.size() - base), 64'(0));
    check("t3_ready", 64'(c1_ready), 64'(1));

    // 4: init_end low holds off the issue
    base = log_addr.size();
    post(0, 26'h40, 16'd3);
    init_end = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_held", 64'(log_addr.size() - base), 64'(0));
    init_end = 1'b1;
    raise = cyc;
    wait_trig(20, seen, at);
    check("t4_trig_seen", 64'(seen), 64'(1));
    check("t4_trig_lat", 64'(at), 64'(raise + 1));
    wait_done(0, 100, seen, at);
    check("t4_done", 64'(seen), 64'(1));
    check_burst("t4_b0", base, 26'h40, 8'd3);

    // 5: data enable and data steering during a c1 burst
    mdelay = 12;
    post(1, 26'h2000, 16'd8);
    wait_trig(20, seen, at);
    check("t5_trig_seen", 64'(seen), 64'(1));
    m_wr_data_en = 1'b1;
    #1 check("t5_issue_en", 64'(c1_data_en), 64'(0));
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_wr_data_en = pat[i];
      c1_data = 32'hA500_0000 + 32'(i);
      c0_data = 32'h5A5A_0000 + 32'(i);
      #1;
      check($sformatf("t5_c1en_%0d", i), 64'(c1_data_en), 64'(pat[i]));
      check($sformatf("t5_c0en_%0d", i), 64'(c0_data_en), 64'(0));
      check($sformatf("t5_data_%0d", i), 64'(m_wr_data), 64'(32'hA500_0000 + 32'(i)));
    end
    m_wr_data_en = 1'b0;
    wait_done(1, 100, seen, at);
    check("t5_done", 64'(seen), 64'(1));
    mdelay = 4;

    // 6: reset during the second burst abandons the transfer
    do_reset();
    base = log_addr.size();
    post(0, 26'h100, 16'd20);
    ntrig = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_wr_trig) ntrig++;
      if (ntrig == 2) break;
    end
    check("t6_two_trigs", 64'(ntrig), 64'(2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_trig", 64'(m_wr_trig), 64'(0));
    check("t6_done", 64'({c1_done, c0_done}), 64'(0));
    check("t6_ready", 64'(c0_ready), 64'(init_end));
    check("t6_len", 64'(m_wr_len), 64'(0));
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (c0_done || c1_done) ndone++;
    end
    check("t6_no_more_bursts", 64'(log_addr.size() - base), 64'(2));
    check("t6_no_done", 64'(ndone), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
